// File: rtl/pwm_compare_dt_16bits.sv
// pwm_compare_dt_16bits: compares the carrier against a shadowed compare value and drives a complementary gate pair with dead time
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   carrier    carrier count from the carrier generator
//   maskevent  single-cycle strobe that loads the shadow registers
//   compare    software compare value, shadowed on maskevent or while stopped
//   deadtime   software dead time in clk cycles, shadowed like compare
//   pwm_onoff  1 runs the leg, 0 forces both gates off
//   pwm_h      high-side gate, active high
//   pwm_l      low-side gate, active high
//   dt_active  high while either dead-time state is occupied
module pwm_compare_dt_16bits #(
    parameter int CNT_W = 16,
    parameter int DT_W  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] carrier,
    input  logic             maskevent,
    input  logic [CNT_W-1:0] compare,
    input  logic [DT_W-1:0]  deadtime,
    input  logic             pwm_onoff,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             dt_active
);
    typedef enum logic [2:0] {OFF, DT_H, H_ON, DT_L, L_ON} state_t;
    state_t           state, state_nx;
    logic [CNT_W-1:0] compare_sh;
    logic [DT_W-1:0]  deadtime_sh, dt_cnt, dt_cnt_nx;
    logic             ref_q, enter;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            compare_sh  <= '0;
            deadtime_sh <= '0;
        end else if (maskevent || !pwm_onoff) begin
            compare_sh  <= compare;
            deadtime_sh <= deadtime;
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) ref_q <= 1'b0;
        else       ref_q <= carrier < compare_sh;
    // Every move toward the side ref_q selects starts a fresh dead time: OFF
    // entry, redirects out of a DT state and exits from an ON state share one
    // path. Unknown encodings fall into the same path and recover cleanly.
    always_comb begin
        enter = !(state inside {DT_H, H_ON, DT_L, L_ON})
             || ((state == DT_H || state == H_ON) && !ref_q)
             || ((state == DT_L || state == L_ON) &&  ref_q);
        state_nx  = state;
        dt_cnt_nx = dt_cnt;
        if (!pwm_onoff)
            state_nx = OFF;
        else if (enter) begin
            state_nx  = (deadtime_sh == '0) ? (ref_q ? H_ON : L_ON) : (ref_q ? DT_H : DT_L);
            dt_cnt_nx = (deadtime_sh == '0) ? '0 : deadtime_sh - DT_W'(1);
        end else if (state == DT_H || state == DT_L) begin
            if (dt_cnt == '0) state_nx = (state == DT_H) ? H_ON : L_ON;
            else              dt_cnt_nx = dt_cnt - DT_W'(1);
        end
    end
    // Outputs are registered from the next-state decode so they change on the
    // same edge as the state register and never glitch.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= OFF;
            dt_cnt    <= '0;
            pwm_h     <= 1'b0;
            pwm_l     <= 1'b0;
            dt_active <= 1'b0;
        end else begin
            state     <= state_nx;
            dt_cnt    <= dt_cnt_nx;
            pwm_h     <= state_nx == H_ON;
            pwm_l     <= state_nx == L_ON;
            dt_active <= state_nx == DT_H || state_nx == DT_L;
        end
    a_gate_excl: assert property (@(posedge clk) disable iff (reset) !(pwm_h && pwm_l));
endmodule

// File: tb/tb_pwm_compare_dt_16bits.sv
// tb_pwm_compare_dt_16bits: directed vector table plus multi-cycle sequences for the dead-time PWM leg
module tb_pwm_compare_dt_16bits;
    logic        clk = 1'b0, reset = 1'b1, maskevent = 1'b0, pwm_onoff = 1'b0;
    logic [15:0] carrier = '0, compare = '0;
    logic [9:0]  deadtime = '0;
    logic        pwm_h, pwm_l, dt_active;
    int tests = 0, fails = 0;
    int nh, nl, nd, nz, nb, zrun, gap_exp;
    bit seen_on, last_h;
    logic [2:0] rec [32];

    typedef struct packed {
        logic [15:0] car;
        logic        mask;
        logic [15:0] cmp;
        logic [9:0]  dt;
        logic        en;
        logic [2:0]  ex;
    } vec_t;
    vec_t vt [33];

    always #5 clk = ~clk;

    pwm_compare_dt_16bits dut (
        .clk(clk), .reset(reset), .carrier(carrier), .maskevent(maskevent),
        .compare(compare), .deadtime(deadtime), .pwm_onoff(pwm_onoff),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .dt_active(dt_active)
    );

    function automatic vec_t v(input int car, input bit m, input int cmp, input int dt, input bit en, input bit [2:0] ex);
        return '{car: 16'(car), mask: m, cmp: 16'(cmp), dt: 10'(dt), en: en, ex: ex};
    endfunction

    function automatic int cnt(input int b, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(rec[i][b]);
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic prelude(input int cmp, input int dt, input int car);
        #2 reset = 1'b1;
        pwm_onoff = 1'b0;
        maskevent = 1'b0;
        tick;
        #2 reset = 1'b0;
        compare  = 16'(cmp);
        deadtime = 10'(dt);
        carrier  = 16'(car);
        tick;
        tick;
        pwm_onoff = 1'b1;
        seen_on = 1'b0;
        zrun = 0;
    endtask

    task automatic sample;
        nh += int'(pwm_h);
        nl += int'(pwm_l);
        nd += int'(dt_active);
        nz += int'(!pwm_h && !pwm_l);
        nb += int'(pwm_h && pwm_l);
        if (!(pwm_h || pwm_l)) zrun++;
        else begin
            if (seen_on && zrun != 0 && pwm_h != last_h) check("dead_gap", zrun, gap_exp);
            zrun = 0;
            seen_on = 1'b1;
            last_h = pwm_h;
        end
    endtask

    task automatic run_saw(input int chg_at, input int new_cmp);
        nh = 0; nl = 0; nd = 0; nz = 0; nb = 0;
        for (int c = 0; c < 2000; c++) begin
            carrier = 16'(c);
            maskevent = (c == 0);
            if (c == chg_at) compare = 16'(new_cmp);
            tick;
            sample;
        end
        maskevent = 1'b0;
    endtask

    task automatic run_const(input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            tick;
            rec[i] = {pwm_h, pwm_l, dt_active};
        end
    endtask

    initial begin
        vt[0]  = v(0,   0, 100, 3, 0, 3'b000);
        vt[1]  = v(0,   0, 100, 3, 1, 3'b001);
        vt[2]  = v(0,   0, 100, 3, 1, 3'b001);
        vt[3]  = v(0,   0, 100, 3, 1, 3'b001);
        vt[4]  = v(0,   0, 100, 3, 1, 3'b001);
        vt[5]  = v(0,   0, 100, 3, 1, 3'b100);
        vt[6]  = v(200, 0, 100, 3, 1, 3'b100);
        vt[7]  = v(200, 0, 100, 3, 1, 3'b001);
        vt[8]  = v(200, 0, 100, 3, 1, 3'b001);
        vt[9]  = v(200, 0, 100, 3, 1, 3'b001);
        vt[10] = v(200, 0, 100, 3, 1, 3'b010);
        vt[11] = v(50,  0, 100, 3, 1, 3'b010);
        vt[12] = v(50,  0, 100, 3, 1, 3'b001);
        vt[13] = v(200, 0, 100, 3, 1, 3'b001);
        vt[14] = v(200, 0, 100, 3, 1, 3'b001);
        vt[15] = v(200, 0, 100, 3, 1, 3'b001);
        vt[16] = v(200, 0, 100, 3, 1, 3'b001);
        vt[17] = v(200, 0, 100, 3, 1, 3'b010);
        vt[18] = v(200, 0, 100, 3, 0, 3'b000);
        vt[19] = v(200, 0, 300, 3, 1, 3'b001);
        vt[20] = v(200, 0, 300, 3, 1, 3'b001);
        vt[21] = v(200, 1, 300, 3, 1, 3'b001);
        vt[22] = v(200, 0, 300, 3, 1, 3'b010);
        vt[23] = v(200, 0, 300, 3, 1, 3'b001);
        vt[24] = v(200, 0, 300, 3, 1, 3'b001);
        vt[25] = v(200, 0, 300, 3, 1, 3'b001);
        vt[26] = v(200, 0, 300, 3, 1, 3'b100);
        vt[27] = v(400, 0, 300, 0, 1, 3'b100);
        vt[28] = v(400, 1, 300, 0, 1, 3'b001);
        vt[29] = v(0,   0, 300, 0, 1, 3'b001);
        vt[30] = v(0,   0, 300, 0, 1, 3'b100);
        vt[31] = v(400, 0, 300, 0, 1, 3'b100);
        vt[32] = v(400, 0, 300, 0, 1, 3'b010);

        tick;
        tick;
        check("reset_outputs", int'({pwm_h, pwm_l, dt_active}), 0);
        #2 reset = 1'b0;

        for (int i = 0; i < 33; i++) begin
            carrier   = vt[i].car;
            maskevent = vt[i].mask;
            compare   = vt[i].cmp;
            deadtime  = vt[i].dt;
            pwm_onoff = vt[i].en;
            tick;
            check($sformatf("vec%0d_hld", i), int'({pwm_h, pwm_l, dt_active}), int'(vt[i].ex));
        end

        prelude(1000, 10, 1999);
        gap_exp = 10;
        run_saw(-1, 0);
        run_saw(-1, 0);
        check("saw_p2_h", nh, 990);
        check("saw_p2_l", nl, 990);
        check("saw_p2_dt", nd, 20);
        run_saw(1500, 500);
        check("saw_p3_h_held", nh, 990);
        check("saw_p3_l_held", nl, 990);
        run_saw(-1, 0);
        check("saw_p4_h_new", nh, 490);
        check("saw_p4_l_new", nl, 1490);
        check("saw_p4_dt", nd, 20);

        prelude(1000, 0, 1999);
        run_saw(-1, 0);
        run_saw(-1, 0);
        check("dt0_h", nh, 1000);
        check("dt0_l", nl, 1000);
        check("dt0_both_low", nz, 0);
        check("dt0_both_high", nb, 0);

        prelude(0, 10, 1999);
        run_saw(-1, 0);
        check("cmp0_h", nh, 0);
        check("cmp0_l", nl, 1990);

        prelude(16'hFFFF, 10, 1999);
        run_saw(-1, 0);
        check("cmpmax_h", nh, 1990);
        check("cmpmax_l", nl, 0);

        prelude(1000, 10, 500);
        run_const(0, 20);
        check("entry_last_dt", int'(rec[9]), 3'b001);
        check("entry_h_on", int'(rec[10]), 3'b100);
        check("entry_dt_count", cnt(0, 20), 10);
        carrier = 16'd1500;
        run_const(0, 3);
        carrier = 16'd500;
        run_const(3, 17);
        check("glitch_h_count", cnt(2, 20), 7);
        check("glitch_l_count", cnt(1, 20), 0);
        check("glitch_dt_count", cnt(0, 20), 13);
        check("glitch_last_dt", int'(rec[13]), 3'b001);
        check("glitch_h_back", int'(rec[14]), 3'b100);

        #2 reset = 1'b1;
        #1;
        check("async_reset_out", int'({pwm_h, pwm_l, dt_active}), 0);
        pwm_onoff = 1'b0;
        tick;
        #2 reset = 1'b0;
        tick;
        tick;
        pwm_onoff = 1'b1;
        run_const(0, 12);
        check("post_reset_last_dt", int'(rec[9]), 3'b001);
        check("post_reset_h_on", int'(rec[10]), 3'b100);
        check("post_reset_dt_count", cnt(0, 12), 10);

        pwm_onoff = 1'b0;
        #1;
        check("onoff_drop_before_edge", int'({pwm_h, pwm_l, dt_active}), 3'b100);
        tick;
        check("onoff_drop_after_edge", int'({pwm_h, pwm_l, dt_active}), 0);
        pwm_onoff = 1'b1;
        run_const(0, 12);
        check("reenable_last_dt", int'(rec[9]), 3'b001);
        check("reenable_h_on", int'(rec[10]), 3'b100);
        check("reenable_dt_count", cnt(0, 12), 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
